// File: rtl/acog_hub_arb.sv
// Round-robin hub arbiter: one 2-cycle window per cog (issue, ack) on the shared hub RAM port and lock unit.
// Define ACOG_HUB_LOCKS_EN to include the lock unit; without it lock ops decode as NOP.
module acog_hub_arb #(
  parameter int NUM_COGS = 8,
  parameter int ADDR_W   = 16
) (
  input  logic                       clk_in,
  input  logic                       reset_in,
  input  logic [NUM_COGS-1:0]        req_in,
  input  logic [5*NUM_COGS-1:0]      op_in,
  input  logic [ADDR_W*NUM_COGS-1:0] addr_in,
  input  logic [32*NUM_COGS-1:0]     wdata_in,
  output logic [NUM_COGS-1:0]        ack_o,
  output logic [31:0]                rdata_o,
  output logic                       c_o,
  output logic [2:0]                 slot_o,
  output logic                       mem_en_o,
  output logic                       mem_we_o,
  output logic [3:0]                 mem_be_o,
  output logic [ADDR_W-3:0]          mem_addr_o,
  output logic [31:0]                mem_wdata_o,
  input  logic [31:0]                mem_rdata_in
);

  localparam int SW = (NUM_COGS > 1) ? $clog2(NUM_COGS) : 1;
  localparam logic [2:0] LAST_SLOT = 3'(NUM_COGS - 1);

  localparam logic [4:0] RDBYTE  = 5'h00, RDWORD  = 5'h01, RDLONG  = 5'h02;
  localparam logic [4:0] WRBYTE  = 5'h04, WRWORD  = 5'h05, WRLONG  = 5'h06;
  localparam logic [4:0] LOCKNEW = 5'h10, LOCKRET = 5'h11, LOCKSET = 5'h12, LOCKCLR = 5'h13;

  logic [2:0]    slot;
  logic          phase;
  logic [SW-1:0] sel;
  logic          pend;
  logic [4:0]    op_q;
  logic [1:0]    lane_q;

  logic [4:0]        cur_op;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       cur_wdata;
  logic              is_rd, is_wr;
  logic [3:0]        wr_be;
  logic [31:0]       wr_data;
  logic [31:0]       rd_fmt;
  logic [31:0]       res_data;
  logic              res_c;

  assign sel       = slot[SW-1:0];
  assign slot_o    = slot;
  assign cur_op    = op_in[5*int'(sel) +: 5];
  assign cur_addr  = addr_in[ADDR_W*int'(sel) +: ADDR_W];
  assign cur_wdata = wdata_in[32*int'(sel) +: 32];
  assign is_rd     = (cur_op == RDBYTE) || (cur_op == RDWORD) || (cur_op == RDLONG);
  assign is_wr     = (cur_op == WRBYTE) || (cur_op == WRWORD) || (cur_op == WRLONG);

  // Narrow writes replicate the data across lanes; the byte enables pick the target lane.
  always_comb begin
    wr_be   = 4'hF;
    wr_data = cur_wdata;
    case (cur_op[1:0])
      2'd0: begin
        wr_be   = 4'b0001 << cur_addr[1:0];
        wr_data = {4{cur_wdata[7:0]}};
      end
      2'd1: begin
        wr_be   = cur_addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{cur_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_fmt = mem_rdata_in;
    case (op_q[1:0])
      2'd0:    rd_fmt = {24'd0, mem_rdata_in[{lane_q, 3'b000} +: 8]};
      2'd1:    rd_fmt = {16'd0, lane_q[1] ? mem_rdata_in[31:16] : mem_rdata_in[15:0]};
      default: ;
    endcase
  end

`ifdef ACOG_HUB_LOCKS_EN
  logic [7:0] lock_bits;
  logic [7:0] alloc_bits;
  logic [2:0] id_q;
  logic       free_ok;
  logic [2:0] free_id;

  always_comb begin
    free_ok = 1'b0;
    free_id = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (!alloc_bits[i]) begin
        free_ok = 1'b1;
        free_id = 3'(i);
      end
    end
  end

  // Only the window owner reaches this edge, so each lock op is atomic.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      lock_bits  <= 8'd0;
      alloc_bits <= 8'd0;
    end else if (phase && pend) begin
      case (op_q)
        LOCKNEW: if (free_ok) alloc_bits[free_id] <= 1'b1;
        LOCKRET: alloc_bits[id_q] <= 1'b0;
        LOCKSET: lock_bits[id_q]  <= 1'b1;
        LOCKCLR: lock_bits[id_q]  <= 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) id_q <= 3'd0;
    else if (!phase) id_q <= cur_wdata[2:0];
  end
`endif

  always_comb begin
    res_data = 32'd0;
    res_c    = 1'b0;
    if ((op_q == RDBYTE) || (op_q == RDWORD) || (op_q == RDLONG)) res_data = rd_fmt;
`ifdef ACOG_HUB_LOCKS_EN
    case (op_q)
      LOCKNEW: begin
        if (free_ok) res_data = {29'd0, free_id};
        else begin
          res_data = 32'd7;
          res_c    = 1'b1;
        end
      end
      LOCKRET: res_data = {29'd0, id_q};
      LOCKSET, LOCKCLR: begin
        res_data = {29'd0, id_q};
        res_c    = lock_bits[id_q];
      end
      default: ;
    endcase
`endif
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      slot        <= 3'd0;
      phase       <= 1'b0;
      pend        <= 1'b0;
      op_q        <= 5'd0;
      lane_q      <= 2'd0;
      ack_o       <= '0;
      rdata_o     <= 32'd0;
      c_o         <= 1'b0;
      mem_en_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_be_o    <= 4'd0;
      mem_addr_o  <= '0;
      mem_wdata_o <= 32'd0;
    end else begin
      phase       <= ~phase;
      ack_o       <= '0;
      rdata_o     <= 32'd0;
      c_o         <= 1'b0;
      mem_en_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_be_o    <= 4'd0;
      mem_addr_o  <= '0;
      mem_wdata_o <= 32'd0;
      if (!phase) begin
        pend   <= req_in[sel];
        op_q   <= cur_op;
        lane_q <= cur_addr[1:0];
        if (req_in[sel] && (is_rd || is_wr)) begin
          mem_en_o   <= 1'b1;
          mem_we_o   <= is_wr;
          mem_addr_o <= cur_addr[ADDR_W-1:2];
          if (is_wr) begin
            mem_be_o    <= wr_be;
            mem_wdata_o <= wr_data;
          end
        end
      end else begin
        pend <= 1'b0;
        slot <= (slot == LAST_SLOT) ? 3'd0 : slot + 3'd1;
        // RAM data for this window is on mem_rdata_in now and is registered with the ack.
        if (pend) begin
          ack_o   <= NUM_COGS'(1) << sel;
          rdata_o <= res_data;
          c_o     <= res_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_acog_hub_arb.sv
// Bench for acog_hub_arb: vector table, multi-cycle sequences and randomized traffic against a transaction model.
module tb_acog_hub_arb;
  localparam int N  = 8;
  localparam int AW = 16;
`ifdef ACOG_HUB_LOCKS_EN
  localparam bit LOCKS = 1'b1;
`else
  localparam bit LOCKS = 1'b0;
`endif

  typedef struct {
    logic [4:0]  op;
    logic [15:0] addr;
    logic [31:0] wd;
  } req_t;

  typedef struct {
    int          cog;
    logic [4:0]  op;
    logic [15:0] addr;
    logic [31:0] wd;
    logic [31:0] er;
    logic        ec;
    bit          lanes;
    logic [3:0]  ebe;
    logic [31:0] ewd;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic [N-1:0]  req;
  logic [4:0]    op_v   [N];
  logic [AW-1:0] addr_v [N];
  logic [31:0]   wd_v   [N];
  logic [5*N-1:0]  op_bus;
  logic [AW*N-1:0] addr_bus;
  logic [32*N-1:0] wd_bus;

  logic [N-1:0]  ack;
  logic [31:0]   rdata;
  logic          carry;
  logic [2:0]    slot;
  logic          mem_en, mem_we;
  logic [3:0]    mem_be;
  logic [AW-3:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  always_comb begin
    op_bus = '0; addr_bus = '0; wd_bus = '0;
    for (int i = 0; i < N; i++) begin
      op_bus[5*i +: 5]    = op_v[i];
      addr_bus[AW*i +: AW] = addr_v[i];
      wd_bus[32*i +: 32]  = wd_v[i];
    end
  end

  acog_hub_arb #(.NUM_COGS(N), .ADDR_W(AW)) dut (
    .clk_in(clk), .reset_in(reset_n), .req_in(req), .op_in(op_bus), .addr_in(addr_bus),
    .wdata_in(wd_bus), .ack_o(ack), .rdata_o(rdata), .c_o(carry), .slot_o(slot),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_in(mem_rdata)
  );

  // Hub RAM: combinational read of the registered address, byte-lane writes on the edge.
  logic [31:0] ram [0:127];
  assign mem_rdata = ram[mem_addr[6:0]];
  always @(posedge clk) begin
    if (mem_en && mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) ram[mem_addr[6:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  // Reference model state: byte-addressed memory and lock arrays.
  logic [7:0] refm [0:511];
  bit lk [8];
  bit al [8];
  req_t q [N][$];
  bit   infl;
  int   infl_cog;
  req_t infl_r;
  int   e;
  int   checks, failures;
  int   acked_cnt [N];
  int   ack_e [N];
  logic [31:0] dut_rd [N];
  logic        dut_c [N];
  logic [3:0]  iss_be [N];
  logic [31:0] iss_wd [N];
  int ack_hist[$];
  int ack_t[$];
  vec_t tv [23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_rd(input logic [4:0] op);
    return op == 5'h00 || op == 5'h01 || op == 5'h02;
  endfunction
  function automatic bit is_wr(input logic [4:0] op);
    return op == 5'h04 || op == 5'h05 || op == 5'h06;
  endfunction

  task automatic exp_lanes(input logic [4:0] op, input logic [15:0] a, input logic [31:0] wd,
                           output logic [3:0] be, output logic [31:0] d);
    if (op == 5'h04) begin be = 4'(1 << (a % 4)); d = {4{wd[7:0]}}; end
    else if (op == 5'h05) begin be = (a % 4 >= 2) ? 4'hC : 4'h3; d = {2{wd[15:0]}}; end
    else begin be = 4'hF; d = wd; end
  endtask

  task automatic exec(input req_t r, output logic [31:0] rd, output logic c);
    int a, id;
    bit found;
    a = int'(r.addr); id = int'(r.wd[2:0]); rd = 0; c = 0; found = 0;
    case (r.op)
      5'h00: rd = {24'd0, refm[a]};
      5'h01: rd = {16'd0, refm[(a/2)*2+1], refm[(a/2)*2]};
      5'h02: rd = {refm[(a/4)*4+3], refm[(a/4)*4+2], refm[(a/4)*4+1], refm[(a/4)*4]};
      5'h04: refm[a] = r.wd[7:0];
      5'h05: begin refm[(a/2)*2] = r.wd[7:0]; refm[(a/2)*2+1] = r.wd[15:8]; end
      5'h06: for (int b = 0; b < 4; b++) refm[(a/4)*4+b] = r.wd[8*b +: 8];
      5'h10: if (LOCKS) begin
        for (int i = 0; i < 8; i++)
          if (!found && !al[i]) begin found = 1; al[i] = 1; rd = i; end
        if (!found) begin rd = 7; c = 1; end
      end
      5'h11: if (LOCKS) begin al[id] = 0; rd = id; end
      5'h12: if (LOCKS) begin c = lk[id]; lk[id] = 1; rd = id; end
      5'h13: if (LOCKS) begin c = lk[id]; lk[id] = 0; rd = id; end
      default: ;
    endcase
  endtask

  task automatic refill();
    req_t r;
    for (int i = 0; i < N; i++)
      if (!req[i] && q[i].size() > 0) begin
        r = q[i].pop_front();
        op_v[i] = r.op; addr_v[i] = r.addr; wd_v[i] = r.wd; req[i] = 1'b1;
      end
  endtask

  task automatic push(input int cog, input logic [4:0] op, input logic [15:0] a, input logic [31:0] wd);
    req_t r;
    r.op = op; r.addr = a; r.wd = wd;
    q[cog].push_back(r);
  endtask

  // One clock: predict this edge from the wheel position (window = edge pair, cog = window mod N).
  task automatic tick();
    int k, c;
    logic [N-1:0] eack;
    logic een, ewe, ec;
    logic [3:0] ebe;
    logic [AW-3:0] ea;
    logic [31:0] ewd, er;
    @(posedge clk); #1;
    e++;
    k = (e - 1) % (2*N); c = k / 2;
    eack = '0; een = 0; ewe = 0; ebe = 0; ea = '0; ewd = 0; er = 0; ec = 0;
    if (k % 2 == 0) begin
      if (req[c]) begin
        infl = 1; infl_cog = c;
        infl_r.op = op_v[c]; infl_r.addr = addr_v[c]; infl_r.wd = wd_v[c];
        if (is_rd(op_v[c]) || is_wr(op_v[c])) begin een = 1; ea = addr_v[c][AW-1:2]; end
        if (is_wr(op_v[c])) begin ewe = 1; exp_lanes(op_v[c], addr_v[c], wd_v[c], ebe, ewd); end
        iss_be[c] = mem_be; iss_wd[c] = mem_wdata;
      end
    end else if (infl) begin
      infl = 0;
      eack = N'(1) << c;
      exec(infl_r, er, ec);
      req[c] = 1'b0;
      acked_cnt[c]++; ack_e[c] = e; dut_rd[c] = rdata; dut_c[c] = carry;
      ack_hist.push_back(c); ack_t.push_back(e);
    end
    chk("ack", 32'(ack), 32'(eack));
    chk("slot", 32'(slot), 32'((e / 2) % N));
    chk("mem_en", 32'(mem_en), 32'(een));
    if (een) begin
      chk("mem_we", 32'(mem_we), 32'(ewe));
      chk("mem_addr", 32'(mem_addr), 32'(ea));
      if (ewe) begin
        chk("mem_be", 32'(mem_be), 32'(ebe));
        chk("mem_wdata", mem_wdata, ewd);
      end
    end
    if (eack != '0) begin
      chk("rdata", rdata, er);
      chk("carry", 32'(carry), 32'(ec));
    end
    refill();
  endtask

  task automatic wait_ack(input int cog, input int target);
    int n;
    n = 0;
    while (acked_cnt[cog] < target && n < 4*N + 8) begin tick(); n++; end
    chk("ack_timeout", 32'(acked_cnt[cog] >= target), 32'd1);
  endtask

  task automatic drain(input int budget);
    int n;
    bool_loop: begin
      n = 0;
      while (n < budget) begin
        bit busy;
        busy = infl || (req != '0);
        for (int i = 0; i < N; i++) if (q[i].size() > 0) busy = 1;
        if (!busy) break;
        tick(); n++;
      end
    end
    chk("drain_timeout", 32'(n < budget), 32'd1);
  endtask

  task automatic model_reset();
    infl = 0; e = 0; req = '0;
    for (int i = 0; i < 8; i++) begin lk[i] = 0; al[i] = 0; end
    for (int i = 0; i < N; i++) q[i].delete();
  endtask

  function automatic vec_t mk(input int cog, input logic [4:0] op, input logic [15:0] a,
                              input logic [31:0] wd, input logic [31:0] er, input logic ec);
    vec_t v;
    v.cog = cog; v.op = op; v.addr = a; v.wd = wd; v.er = er; v.ec = ec;
    v.lanes = 0; v.ebe = 0; v.ewd = 0;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, cnt4, n;
    logic [7:0] w8;
    checks = 0; failures = 0;

    tv[0]  = mk(0, 5'h04, 16'h0007, 32'h000000A5, 32'h0, 1'b0);
    tv[0].lanes = 1; tv[0].ebe = 4'b1000; tv[0].ewd = 32'hA5A5A5A5;
    tv[1]  = mk(0, 5'h01, 16'h0006, 32'h0, 32'h0000A523, 1'b0);
    tv[2]  = mk(7, 5'h00, 16'h0005, 32'h0, 32'h00000032, 1'b0);
    tv[3]  = mk(4, 5'h05, 16'h000B, 32'h1234BEEF, 32'h0, 1'b0);
    tv[3].lanes = 1; tv[3].ebe = 4'b1100; tv[3].ewd = 32'hBEEFBEEF;
    tv[4]  = mk(4, 5'h02, 16'h0008, 32'h0, 32'hBEEF3146, 1'b0);
    tv[5]  = mk(6, 5'h01, 16'h000A, 32'h0, 32'h0000BEEF, 1'b0);
    tv[6]  = mk(6, 5'h03, 16'h0010, 32'h12345678, 32'h0, 1'b0);
    tv[7]  = mk(5, 5'h1F, 16'h0010, 32'hFFFFFFFF, 32'h0, 1'b0);
    for (int i = 0; i < 8; i++)
      tv[8+i] = mk(1, 5'h10, 16'h0, 32'h0, LOCKS ? 32'(i) : 32'd0, 1'b0);
    tv[16] = mk(1, 5'h10, 16'h0, 32'h0, LOCKS ? 32'd7 : 32'd0, LOCKS);
    tv[17] = mk(2, 5'h12, 16'h0, 32'h4, LOCKS ? 32'd4 : 32'd0, 1'b0);
    tv[18] = mk(2, 5'h12, 16'h0, 32'h4, LOCKS ? 32'd4 : 32'd0, LOCKS);
    tv[19] = mk(2, 5'h13, 16'h0, 32'h4, LOCKS ? 32'd4 : 32'd0, LOCKS);
    tv[20] = mk(2, 5'h11, 16'h0, 32'h4, LOCKS ? 32'd4 : 32'd0, 1'b0);
    tv[21] = mk(1, 5'h10, 16'h0, 32'h0, LOCKS ? 32'd4 : 32'd0, 1'b0);
    tv[22] = mk(5, 5'h12, 16'h0, 32'h2, LOCKS ? 32'd2 : 32'd0, 1'b0);

    for (int w = 0; w < 128; w++) begin
      w8 = 8'(w);
      ram[w] = {w8 ^ 8'h11, w8 ^ 8'h22, w8 ^ 8'h33, w8 ^ 8'h44};
    end
    ram[65] = 32'hDEADBEEF;
    for (int b = 0; b < 512; b++) refm[b] = ram[b/4][8*(b%4) +: 8];
    for (int i = 0; i < N; i++) begin
      op_v[i] = 0; addr_v[i] = 0; wd_v[i] = 0; acked_cnt[i] = 0; ack_e[i] = 0;
    end

    reset_n = 1'b0;
    model_reset();
    #1;
    chk("reset_ack", 32'(ack), 32'd0);
    chk("reset_slot", 32'(slot), 32'd0);
    chk("reset_mem_en", 32'(mem_en), 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // First request after reset: cog 3 RDLONG, ack on the 8th edge.
    push(3, 5'h02, 16'h0104, 32'h0);
    refill();
    wait_ack(3, 1);
    chk("first_ack_edge", 32'(ack_e[3]), 32'd8);
    chk("first_ack_data", dut_rd[3], 32'hDEADBEEF);

    for (int i = 0; i < 23; i++) begin
      t0 = acked_cnt[tv[i].cog] + 1;
      push(tv[i].cog, tv[i].op, tv[i].addr, tv[i].wd);
      refill();
      wait_ack(tv[i].cog, t0);
      chk($sformatf("vec%0d_rdata", i), dut_rd[tv[i].cog], tv[i].er);
      chk($sformatf("vec%0d_c", i), 32'(dut_c[tv[i].cog]), 32'(tv[i].ec));
      if (tv[i].lanes) begin
        chk($sformatf("vec%0d_be", i), 32'(iss_be[tv[i].cog]), 32'(tv[i].ebe));
        chk($sformatf("vec%0d_wdata", i), iss_wd[tv[i].cog], tv[i].ewd);
      end
    end

    // All cogs requesting at once, starting at the top of the wheel.
    n = 0;
    while (e % (2*N) != 0 && n < 2*N) begin tick(); n++; end
    ack_hist.delete(); ack_t.delete();
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < N; i++) push(i, 5'h02, 16'(4*i + 64*r), 32'h0);
    refill();
    drain(200);
    chk("all_cogs_count", 32'(ack_hist.size()), 32'(3*N));
    if (ack_hist.size() > 0) chk("all_cogs_first", 32'(ack_hist[0]), 32'd0);
    for (int j = 1; j < ack_hist.size(); j++) begin
      chk("all_cogs_order", 32'(ack_hist[j]), 32'((ack_hist[j-1] + 1) % N));
      chk("all_cogs_spacing", 32'(ack_t[j] - ack_t[j-1]), 32'd2);
    end

    // Reset while a read is on the RAM port.
    push(2, 5'h12, 16'h0, 32'h6);
    refill();
    wait_ack(2, acked_cnt[2] + 1);
    push(4, 5'h02, 16'h0010, 32'h0);
    refill();
    cnt4 = acked_cnt[4];
    n = 0;
    while (!(infl && infl_cog == 4) && n < 4*N) begin tick(); n++; end
    chk("pre_reset_mem_en", 32'(mem_en), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_reset_mem_en", 32'(mem_en), 32'd0);
    chk("mid_reset_mem_addr", 32'(mem_addr), 32'd0);
    chk("mid_reset_slot", 32'(slot), 32'd0);
    chk("mid_reset_ack", 32'(ack), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2*N + 2) tick();
    chk("dropped_no_ack", 32'(acked_cnt[4]), 32'(cnt4));
    push(2, 5'h12, 16'h0, 32'h6);
    refill();
    wait_ack(2, acked_cnt[2] + 1);
    chk("post_reset_lockset_c", 32'(dut_c[2]), 32'd0);
    chk("post_reset_lockset_id", dut_rd[2], LOCKS ? 32'd6 : 32'd0);
    push(1, 5'h10, 16'h0, 32'h0);
    refill();
    wait_ack(1, acked_cnt[1] + 1);
    chk("post_reset_locknew", dut_rd[1], 32'd0);

    // Randomized traffic across all cogs and ops.
    for (int i = 0; i < 300; i++) begin
      logic [4:0] ops [12];
      ops = '{5'h00, 5'h01, 5'h02, 5'h04, 5'h05, 5'h06, 5'h10, 5'h11, 5'h12, 5'h13, 5'h03, 5'h1F};
      push(int'($urandom_range(0, N-1)), ops[$urandom_range(0, 11)],
           16'($urandom_range(0, 63)), $urandom);
    end
    refill();
    drain(20000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/acog_hub_arb.md
# acog_hub_arb

Hub-memory arbiter for the ACog array. It shares the single 32-bit hub RAM port, and the hub lock bits, between all cogs using a fixed round-robin slot wheel. Each cog owns one 2-cycle window per rotation. A pending request issues in phase 0 of the window and is acknowledged in phase 1; the cog sequencer stays in its read stage until that ack arrives.

## Interface
Parameters:
- NUM_COGS, 8: number of requesters; power of two, 2..8.
- ADDR_W, 16: hub byte-address width; RAM word address is ADDR_W-2 bits.

Ports:
- clk_in  input  1  system clock; all state on rising edge.
- reset_in  input  1  asynchronous, active-low reset.
- req_in  input  NUM_COGS  per-cog request level; held high until that cog's ack.
- op_in  input  5*NUM_COGS  per-cog hub op, cog i at [5i+4:5i]; stable while req high.
- addr_in  input  ADDR_W*NUM_COGS  per-cog byte address; stable while req high.
- wdata_in  input  32*NUM_COGS  per-cog write data / lock id; stable while req high.
- ack_o  output  NUM_COGS  one-cycle ack pulse, one-hot or zero.
- rdata_o  output  32  result, valid in the ack cycle.
- c_o  output  1  carry result, valid in the ack cycle.
- slot_o  output  3  cog currently owning the window.
- mem_en_o  output  1  RAM access strobe.
- mem_we_o  output  1  RAM write.
- mem_be_o  output  4  RAM byte enables.
- mem_addr_o  output  ADDR_W-2  RAM word address.
- mem_wdata_o  output  32  RAM write data.
- mem_rdata_in  input  32  RAM read data, one cycle after mem_en_o.

## Operation
- Op encoding:
  - 0x00 RDBYTE, 0x01 RDWORD, 0x02 RDLONG
  - 0x04 WRBYTE, 0x05 WRWORD, 0x06 WRLONG
  - 0x10 LOCKNEW, 0x11 LOCKRET, 0x12 LOCKSET, 0x13 LOCKCLR
  - Any other value is a NOP: acked with rdata_o=0, c_o=0, no RAM access.
- Slot wheel: 3-bit slot counter plus 1-bit phase.
  - Phase toggles every cycle.
  - Slot increments when phase goes 1->0 and wraps from NUM_COGS-1 to 0.
- Phase 0 (ISSUE): if req_in[slot] is high, latch op and addr, then:
  - RD: mem_en_o=1, mem_we_o=0.
  - WR: mem_en_o=1, mem_we_o=1 with byte enables below.
  - Lock op or NOP: no RAM access.
- Phase 1 (ACK): ack_o[slot]=1; rdata_o and c_o are valid. If req was low at ISSUE, no ack.
- Byte lanes:
  - BYTE: lane addr[1:0], mem_be_o=1<<addr[1:0], wdata[7:0] replicated to all 4 lanes; read data zero-extended.
  - WORD: half addr[1], mem_be_o=4'b0011 or 4'b1100, wdata[15:0] replicated; addr[0] ignored; read zero-extended.
  - LONG: mem_be_o=4'hF; addr[1:0] ignored.
- Writes return rdata_o=0, c_o=0.
- Locks: 8 lock bits plus 8 allocated bits; id = wdata[2:0].
  - LOCKNEW: allocates the lowest free id; rdata_o=id, c_o=0. If none is free: rdata_o=7, c_o=1, no state change.
  - LOCKRET: clears allocated[id]; the lock bit is unchanged; c_o=0.
  - LOCKSET: c_o = old lock[id]; then sets lock[id].
  - LOCKCLR: c_o = old lock[id]; then clears lock[id].
  - LOCKSET/LOCKCLR return rdata_o=id.
  - Lock state updates at the ACK edge.
- Only one cog is served per window, so lock ops are atomic by construction.

## Timing
- Reset (asynchronous, takes effect immediately, including mid-access):
  - slot=0, phase=0, ack_o=0, rdata_o=0, c_o=0.
  - mem_en_o=0, mem_we_o=0, mem_be_o=0, mem_addr_o=0, mem_wdata_o=0.
  - All lock and allocated bits 0.
  - An in-flight access is dropped without an ack.
- First ISSUE after reset deassertion: slot 0, phase 0.
- mem_* outputs are registered and asserted for exactly the one ISSUE-following cycle.
- rdata_o is captured from mem_rdata_in in that same cycle and registered out with ack_o.
- Latency from request to ack: 2 cycles best case (req high at the cycle before its ISSUE edge); 2*NUM_COGS+1 cycles worst case.
- Back-to-back requests from one cog are served one per rotation (every 2*NUM_COGS cycles).
- A cog raising req during its own ACK phase waits for the next rotation.
- Dropping req before ack is a protocol violation; behaviour is undefined.

## Configuration
- ACOG_HUB_LOCKS_EN defined: the lock unit is present as specified above.
- ACOG_HUB_LOCKS_EN undefined:
  - The lock unit is removed; ops 0x10-0x13 decode as NOP (rdata_o=0, c_o=0).
  - Memory timing is unchanged.

## Test plan
- After reset release, cog 3 holds RDLONG addr 0x0104 with RAM word 0x41 = 0xDEADBEEF -> mem_en_o pulses with mem_addr_o=0x41 in slot 3; ack_o=8'h08 with rdata_o=0xDEADBEEF, 8 cycles after reset release.
- Cog 0 issues WRBYTE addr 0x0007 data 0xA5, then RDWORD addr 0x0006 -> mem_be_o=4'b1000, mem_wdata_o=0xA5A5A5A5; the read returns 0x0000A5xx zero-extended, where xx is the prior byte.
- All 8 cogs hold req simultaneously -> acks arrive one per 2 cycles in order 0..7 and repeat; no two ack bits are ever high together.
- Cog 1 issues LOCKNEW 9 times -> ids 0..7 with c_o=0, then c_o=1. Cog 2 LOCKSET id 4 twice -> c_o=0 then 1. LOCKCLR -> c_o=1. LOCKRET 4, then LOCKNEW -> id 4.
- reset_in asserted in the cycle mem_en_o=1 -> all outputs 0 immediately; no ack for that request; lock bits cleared.
- Build with ACOG_HUB_LOCKS_EN undefined, cog 5 issues LOCKSET id 2 -> ack with rdata_o=0, c_o=0; mem_en_o stays 0.
